// File: rtl/tl_pkg.sv
// Shared definitions for the transaction-layer FIFO bank controller:
// the one-hot FIFO state bus encodings, the default thresholds and the word width.
package tl_pkg;

  localparam int DATA_W = 12;
  localparam int AF_DEF = 6;
  localparam int AE_DEF = 0;

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester above last_grant,
// wrapping modulo NUM_REQ, and reports it both one-hot and as a binary index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    // NUM_REQ is a power of two, so IDX_W-bit addition wraps modulo NUM_REQ.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = last_grant + IDX_W'(k);
      if (enable && !w_found && req[w_cand]) begin
        grant[w_cand] = 1'b1;
        grant_idx     = w_cand;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_fifo_arbiter.sv
// FIFO-bank controller: sequences the RESET/INIT/IDLE/ACTIVE state bus, broadcasts
// thresholds and drains the input FIFOs round-robin into the output FIFO.
module tl_fifo_arbiter #(
  parameter int DATA_W  = tl_pkg::DATA_W,
  parameter int NUM_REQ = 4,
  parameter int TH_W    = 3,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [TH_W-1:0]           umbral_AF_in,
  input  logic [TH_W-1:0]           umbral_AE_in,
  input  logic [NUM_REQ-1:0]        in_empty,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  input  logic                      out_almost_full,
  output logic [3:0]                state,
  output logic [TH_W-1:0]           umbral_AF,
  output logic [TH_W-1:0]           umbral_AE,
  output logic [NUM_REQ-1:0]        pop,
  output logic                      out_push,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          grant_idx,
  output logic [CNT_W-1:0]          words_fwd
);

  import tl_pkg::*;

  state_e             r_state;
  logic [TH_W-1:0]    r_umbral_af;
  logic [TH_W-1:0]    r_umbral_ae;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic               r_out_push;
  logic [CNT_W-1:0]   r_words_fwd;

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_arb_en;

  assign w_req      = ~in_empty;
  assign w_eligible = w_req & {NUM_REQ{~out_almost_full}};
  // Gated by the registered state, so an async reset kills pop immediately.
  assign w_arb_en   = (r_state == ST_ACTIVE) && !out_almost_full;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (w_req),
    .last_grant (r_last_grant),
    .enable     (w_arb_en),
    .grant      (w_grant),
    .grant_idx  (w_win_idx)
  );

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RESET;
      r_umbral_af <= TH_W'(AF_DEF);
      r_umbral_ae <= TH_W'(AE_DEF);
    end else begin
      unique case (r_state)
        ST_RESET: r_state <= ST_INIT;
        ST_INIT: begin
          r_umbral_af <= umbral_AF_in;
          r_umbral_ae <= umbral_AE_in;
          if (!init) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (init)             r_state <= ST_INIT;
          else if (|w_eligible) r_state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          // Stay until the word popped last cycle has actually been pushed.
          if (!(|w_eligible) && !r_out_push) r_state <= ST_IDLE;
        end
        default: r_state <= ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant_idx  <= '0;
      r_out_push   <= 1'b0;
      r_words_fwd  <= '0;
    end else begin
      r_out_push <= |w_grant;
      if (|w_grant) begin
        r_last_grant <= w_win_idx;
        r_grant_idx  <= w_win_idx;
      end
      if (r_out_push) r_words_fwd <= r_words_fwd + CNT_W'(1);
    end
  end

  assign state     = r_state;
  assign umbral_AF = r_umbral_af;
  assign umbral_AE = r_umbral_ae;
  assign pop       = w_grant;
  assign out_push  = r_out_push;
  assign grant_idx = r_grant_idx;
  assign words_fwd = r_words_fwd;
  // The input FIFO registered the popped word last cycle; select it now.
  assign out_data  = in_data[int'(r_grant_idx) * DATA_W +: DATA_W];

endmodule

// File: tb/tb_tl_fifo_arbiter.sv
// Directed self-checking bench for tl_fifo_arbiter: reset sequencing, single
// requester, skipping empties, round-robin, back-pressure and async reset.
module tb_tl_fifo_arbiter;

  localparam int DATA_W  = 12;
  localparam int NUM_REQ = 4;
  localparam int TH_W    = 3;
  localparam int CNT_W   = 16;
  localparam int IDX_W   = 2;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      init;
  logic [TH_W-1:0]           umbral_AF_in;
  logic [TH_W-1:0]           umbral_AE_in;
  logic [NUM_REQ-1:0]        in_empty;
  logic [NUM_REQ*DATA_W-1:0] in_data;
  logic                      out_almost_full;
  logic [3:0]                state;
  logic [TH_W-1:0]           umbral_AF;
  logic [TH_W-1:0]           umbral_AE;
  logic [NUM_REQ-1:0]        pop;
  logic                      out_push;
  logic [DATA_W-1:0]         out_data;
  logic [IDX_W-1:0]          grant_idx;
  logic [CNT_W-1:0]          words_fwd;

  int n_checks = 0;
  int n_errors = 0;

  tl_fifo_arbiter #(
    .DATA_W  (DATA_W),
    .NUM_REQ (NUM_REQ),
    .TH_W    (TH_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .umbral_AF_in    (umbral_AF_in),
    .umbral_AE_in    (umbral_AE_in),
    .in_empty        (in_empty),
    .in_data         (in_data),
    .out_almost_full (out_almost_full),
    .state           (state),
    .umbral_AF       (umbral_AF),
    .umbral_AE       (umbral_AE),
    .pop             (pop),
    .out_push        (out_push),
    .out_data        (out_data),
    .grant_idx       (grant_idx),
    .words_fwd       (words_fwd)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                          input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3);
    in_data = {d3, d2, d1, d0};
  endtask

  task automatic do_reset();
    reset = 1'b0;
    init  = 1'b0;
    in_empty = '1;
    out_almost_full = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    n_checks++;
    if (state !== 4'b0100) begin n_errors++; $display("FAIL do_reset_idle state=%b exp=0100", state); end
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b1; umbral_AF_in = 3'd5; umbral_AE_in = 3'd1;
    in_empty = '1; out_almost_full = 1'b0; set_data(12'h000, 12'h000, 12'h000, 12'h000);
    cyc();
    cyc();
    n_checks++;
    if (state !== 4'b0001) begin n_errors++; $display("FAIL rst_state state=%b exp=0001", state); end
    n_checks++;
    if (umbral_AF !== 3'd6 || umbral_AE !== 3'd0) begin
      n_errors++; $display("FAIL rst_umbral af=%0d ae=%0d exp=6/0", umbral_AF, umbral_AE);
    end
    n_checks++;
    if (pop !== 4'b0000 || out_push !== 1'b0 || grant_idx !== 2'd0 || words_fwd !== 16'd0) begin
      n_errors++;
      $display("FAIL rst_outputs pop=%b push=%b gidx=%0d words=%0d exp=0000/0/0/0", pop, out_push, grant_idx, words_fwd);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (state !== 4'b0001) begin n_errors++; $display("FAIL rst_hold state=%b exp=0001", state); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (state !== 4'b0010) begin n_errors++; $display("FAIL init_cycle%0d state=%b exp=0010", i, state); end
      if (i == 2) init = 1'b0;
    end
    cyc();
    n_checks++;
    if (state !== 4'b0100) begin n_errors++; $display("FAIL idle_entry state=%b exp=0100", state); end
    n_checks++;
    if (umbral_AF !== 3'd5 || umbral_AE !== 3'd1) begin
      n_errors++; $display("FAIL init_umbral af=%0d ae=%0d exp=5/1", umbral_AF, umbral_AE);
    end
    cyc();
    n_checks++;
    if (state !== 4'b0100 || pop !== 4'b0000) begin
      n_errors++; $display("FAIL idle_hold state=%b pop=%b exp=0100/0000", state, pop);
    end
  endtask

  task automatic test_single();
    in_empty = 4'b1110;
    set_data(12'hA5A, 12'h111, 12'h222, 12'h333);
    #1;
    n_checks++;
    if (state !== 4'b0100 || pop !== 4'b0000) begin
      n_errors++; $display("FAIL single_idle state=%b pop=%b exp=0100/0000", state, pop);
    end
    cyc();
    n_checks++;
    if (state !== 4'b1000 || pop !== 4'b0001) begin
      n_errors++; $display("FAIL single_pop state=%b pop=%b exp=1000/0001", state, pop);
    end
    cyc();
    in_empty = 4'b1111;
    #1;
    n_checks++;
    if (out_push !== 1'b1 || out_data !== 12'hA5A || grant_idx !== 2'd0 || pop !== 4'b0000) begin
      n_errors++;
      $display("FAIL single_push push=%b data=%h gidx=%0d pop=%b exp=1/a5a/0/0000", out_push, out_data, grant_idx, pop);
    end
    cyc();
    n_checks++;
    if (words_fwd !== 16'd1 || out_push !== 1'b0) begin
      n_errors++; $display("FAIL single_count words=%0d push=%b exp=1/0", words_fwd, out_push);
    end
    cyc();
    n_checks++;
    if (state !== 4'b0100) begin n_errors++; $display("FAIL single_back_idle state=%b exp=0100", state); end
  endtask

  task automatic test_skip_empties();
    logic [3:0] exp_pop [4];
    logic [1:0] exp_idx [4];
    exp_pop = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
    exp_idx = '{2'd2, 2'd0, 2'd2, 2'd0};
    in_empty = 4'b1010;
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (pop !== exp_pop[i]) begin n_errors++; $display("FAIL skip_pop%0d pop=%b exp=%b", i, pop, exp_pop[i]); end
      if (i > 0) begin
        n_checks++;
        if (grant_idx !== exp_idx[i-1] || out_push !== 1'b1) begin
          n_errors++; $display("FAIL skip_gidx%0d gidx=%0d push=%b exp=%0d/1", i, grant_idx, out_push, exp_idx[i-1]);
        end
      end
      cyc();
    end
    in_empty = 4'b1111;
    #1;
    n_checks++;
    if (grant_idx !== 2'd0 || out_push !== 1'b1) begin
      n_errors++; $display("FAIL skip_last gidx=%0d push=%b exp=0/1", grant_idx, out_push);
    end
    cyc();
    cyc();
    n_checks++;
    if (state !== 4'b0100) begin n_errors++; $display("FAIL skip_idle state=%b exp=0100", state); end
  endtask

  task automatic test_round_robin();
    logic [DATA_W-1:0] d [4];
    logic [3:0] exp_pop;
    d = '{12'h0C1, 12'h1C2, 12'h2C3, 12'h3C4};
    do_reset();
    set_data(d[0], d[1], d[2], d[3]);
    in_empty = 4'b0000;
    cyc();
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_pop = 4'b0001 << (i % 4);
      n_checks++;
      if (pop !== exp_pop) begin n_errors++; $display("FAIL rr_pop%0d pop=%b exp=%b", i, pop, exp_pop); end
      n_checks++;
      if (i == 0) begin
        if (out_push !== 1'b0) begin n_errors++; $display("FAIL rr_push0 push=%b exp=0", out_push); end
      end else if (out_push !== 1'b1 || out_data !== d[(i-1)%4] || grant_idx !== 2'((i-1)%4)) begin
        n_errors++;
        $display("FAIL rr_push%0d push=%b data=%h gidx=%0d exp=1/%h/%0d", i, out_push, out_data, grant_idx, d[(i-1)%4], (i-1)%4);
      end
      cyc();
    end
    in_empty = 4'b1111;
    #1;
    n_checks++;
    if (out_push !== 1'b1 || out_data !== d[3] || pop !== 4'b0000) begin
      n_errors++; $display("FAIL rr_tail push=%b data=%h pop=%b exp=1/%h/0000", out_push, out_data, pop, d[3]);
    end
    cyc();
    n_checks++;
    if (words_fwd !== 16'd8) begin n_errors++; $display("FAIL rr_count words=%0d exp=8", words_fwd); end
    cyc();
    n_checks++;
    if (state !== 4'b0100) begin n_errors++; $display("FAIL rr_idle state=%b exp=0100", state); end
  endtask

  task automatic test_back_pressure();
    in_empty = 4'b0000;
    cyc();
    #1;
    n_checks++;
    if (pop !== 4'b0001) begin n_errors++; $display("FAIL bp_pop0 pop=%b exp=0001", pop); end
    cyc();
    #1;
    n_checks++;
    if (pop !== 4'b0010 || out_push !== 1'b1) begin
      n_errors++; $display("FAIL bp_pop1 pop=%b push=%b exp=0010/1", pop, out_push);
    end
    cyc();
    out_almost_full = 1'b1;
    #1;
    n_checks++;
    if (pop !== 4'b0000 || out_push !== 1'b1 || grant_idx !== 2'd1) begin
      n_errors++; $display("FAIL bp_block pop=%b push=%b gidx=%0d exp=0000/1/1", pop, out_push, grant_idx);
    end
    cyc();
    n_checks++;
    if (pop !== 4'b0000 || out_push !== 1'b0) begin
      n_errors++; $display("FAIL bp_drained pop=%b push=%b exp=0000/0", pop, out_push);
    end
    cyc();
    n_checks++;
    if (state !== 4'b0100 || out_push !== 1'b0) begin
      n_errors++; $display("FAIL bp_idle state=%b push=%b exp=0100/0", state, out_push);
    end
    cyc();
    n_checks++;
    if (state !== 4'b0100 || pop !== 4'b0000) begin
      n_errors++; $display("FAIL bp_hold state=%b pop=%b exp=0100/0000", state, pop);
    end
    out_almost_full = 1'b0;
    cyc();
    n_checks++;
    if (state !== 4'b1000 || pop !== 4'b0100) begin
      n_errors++; $display("FAIL bp_resume state=%b pop=%b exp=1000/0100", state, pop);
    end
    cyc();
    n_checks++;
    if (out_push !== 1'b1 || grant_idx !== 2'd2 || pop !== 4'b1000) begin
      n_errors++; $display("FAIL bp_resume_push push=%b gidx=%0d pop=%b exp=1/2/1000", out_push, grant_idx, pop);
    end
  endtask

  task automatic test_async_reset();
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (pop !== 4'b0000 || out_push !== 1'b0 || state !== 4'b0001 || words_fwd !== 16'd0) begin
      n_errors++;
      $display("FAIL async_rst pop=%b push=%b state=%b words=%0d exp=0000/0/0001/0", pop, out_push, state, words_fwd);
    end
    cyc();
    reset = 1'b1;
    #1;
    n_checks++;
    if (state !== 4'b0001 || pop !== 4'b0000) begin
      n_errors++; $display("FAIL async_release state=%b pop=%b exp=0001/0000", state, pop);
    end
    cyc();
    n_checks++;
    if (state !== 4'b0010 || pop !== 4'b0000) begin
      n_errors++; $display("FAIL async_init state=%b pop=%b exp=0010/0000", state, pop);
    end
    cyc();
    n_checks++;
    if (state !== 4'b0100 || pop !== 4'b0000) begin
      n_errors++; $display("FAIL async_idle state=%b pop=%b exp=0100/0000", state, pop);
    end
    cyc();
    n_checks++;
    if (state !== 4'b1000 || pop !== 4'b0001) begin
      n_errors++; $display("FAIL async_first_grant state=%b pop=%b exp=1000/0001", state, pop);
    end
    cyc();
    n_checks++;
    if (out_push !== 1'b1 || grant_idx !== 2'd0) begin
      n_errors++; $display("FAIL async_first_push push=%b gidx=%0d exp=1/0", out_push, grant_idx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_skip_empties();
    test_round_robin();
    test_back_pressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tl_fifo_arbiter.md
Name: tl_fifo_arbiter

Overview:
Controller and round-robin arbiter for the transaction-layer FIFO bank. It sequences the shared 4-bit FIFO state bus (RESET/INIT/IDLE/ACTIVE) and broadcasts the almost-full/almost-empty thresholds. In ACTIVE it drains up to NUM_REQ per-class input FIFOs, one word per cycle, into a single downstream output FIFO, and honours back-pressure from that FIFO's almost_full.

Parameters:
DATA_W, 12, FIFO word width
NUM_REQ, 4, number of input FIFOs; power of two, 2..8
TH_W, 3, threshold width, matching the FIFO umbral ports
CNT_W, 16, width of the forwarded-word counter

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
init  in  1  request to enter INIT and load thresholds
umbral_AF_in  in  TH_W  almost-full threshold to load in INIT
umbral_AE_in  in  TH_W  almost-empty threshold to load in INIT
in_empty  in  NUM_REQ  exact empty flag per input FIFO
in_data  in  NUM_REQ*DATA_W  input FIFO data_out values, packed; requester i at [i*DATA_W +: DATA_W]
out_almost_full  in  1  almost_full from the output FIFO
state  out  4  one-hot FIFO state bus: 0001 RESET, 0010 INIT, 0100 IDLE, 1000 ACTIVE
umbral_AF  out  TH_W  registered threshold broadcast
umbral_AE  out  TH_W  registered threshold broadcast
pop  out  NUM_REQ  one-hot pop to input FIFOs
out_push  out  1  push to the output FIFO
out_data  out  DATA_W  data to the output FIFO
grant_idx  out  log2(NUM_REQ)  requester whose word is on out_data
words_fwd  out  CNT_W  count of words pushed; wraps modulo 2^CNT_W

Behaviour:
- Reset values (asynchronous, while reset=0): state=0001, umbral_AF=6, umbral_AE=0, pop=0, out_push=0, grant_idx=0, words_fwd=0, last_grant=NUM_REQ-1 so that the first grant goes to requester 0.
- FSM:
  - RESET: held for exactly one cycle after reset deasserts, then goes to INIT.
  - INIT: umbral_AF and umbral_AE load from their inputs every cycle. Stays in INIT while init=1; goes to IDLE when init=0.
  - IDLE: no pops. If init=1, goes to INIT. Otherwise goes to ACTIVE when eligible is non-zero, where eligible = ~in_empty and out_almost_full=0.
  - ACTIVE: arbitrates. Goes to IDLE when eligible=0 and no push is pending. init is ignored in ACTIVE.
- Arbitration, in ACTIVE only:
  - If out_almost_full=0 and any ~in_empty bit is set, grant the first non-empty requester searching upward from last_grant+1, modulo NUM_REQ.
  - pop is combinational from registered state, last_grant, in_empty and out_almost_full. It is one-hot or zero, and is never asserted to an empty FIFO.
  - last_grant updates to the winner on the same edge.
- Datapath latency is one cycle:
  - A pop in cycle N causes the FIFO to register the word at the end of N.
  - In cycle N+1, out_push=1 (registered copy of |pop), grant_idx holds the registered winner, and out_data = in_data[grant_idx] (combinational mux).
  - Back-to-back grants produce one push per cycle.
- Back-pressure: out_almost_full=1 blocks new grants from that cycle on. The in-flight word from cycle N-1 is still pushed, because the threshold margin absorbs it.
- Leaving ACTIVE: the transition to IDLE occurs only after the last pending push has completed.
- Counter: words_fwd increments on every cycle with out_push=1.
- Reset mid-operation: in-flight data is dropped; pop and out_push go to 0 immediately, asynchronously.
- Inputs outside ACTIVE: in_empty and in_data are ignored; pop=0 in every state except ACTIVE.
- Width rules: grant index arithmetic wraps modulo NUM_REQ; thresholds pass through with no range check.

Decomposition:
- Shared package tl_pkg: state encodings ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE; default thresholds AF_DEF=6, AE_DEF=0; DATA_W.
- Sub-module rr_arbiter: NUM_REQ-wide, purely combinational. Inputs are req, last_grant and enable; outputs are a one-hot grant and a binary index. The FSM, registers and data mux remain in tl_fifo_arbiter.

Test Plan:
- Reset sequence: release reset with init=1 for 3 cycles and umbral_AF_in=5, umbral_AE_in=1. Required: state=0001 for 1 cycle, then 0010 for 3 cycles, then 0100; umbral_AF=5 and umbral_AE=1 held.
- Single requester: in_empty=1110, in_data[0]=12'hA5A. Required: state goes to 1000; pop=0001; out_push=1 one cycle later with out_data=A5A and grant_idx=0; words_fwd=1.
- Round-robin: all four FIFOs non-empty for 8 cycles. Required: pop sequence 0001, 0010, 0100, 1000, 0001, ...; 8 pushes, each one cycle behind its pop; words_fwd=8.
- Back-pressure: out_almost_full rises during a stream. Required: pop=0 from that cycle on, exactly one more out_push, then state=0100; streaming resumes when out_almost_full falls.
- Skip empties: in_empty=1010 starting from last_grant=0. Required: grants alternate 2, 0, 2, 0; never 1 or 3.
- Async reset mid-stream: assert reset low between clock edges. Required: pop=0, out_push=0, state=0001 immediately; after release, the first grant goes to requester 0.
